// File: rtl/pulse_stretch_pkg.sv
// ============================================================================
// pulse_stretch_pkg : shared state encoding and timing defaults | rev 1.0
// ============================================================================
`default_nettype none

package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  // 333333 clocks = 0.01 s at 33.3333 MHz
  localparam int DEFAULT_CYCLES = 333333;
  localparam int PEND_W         = 3;

endpackage

`default_nettype wire

// File: rtl/pulse_stretch_if.sv
// ============================================================================
// pulse_stretch_if : strobe-in / stretched-out signal bundle | rev 1.0
// ============================================================================
`default_nettype none

interface pulse_stretch_if;
  import pulse_stretch_pkg::*;

  logic              trigger;
  logic              clear;
  logic              stretched;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output trigger, clear,
    input  stretched, busy, pending, overflow
  );

  modport slave (
    input  trigger, clear,
    output stretched, busy, pending, overflow
  );

endinterface

`default_nettype wire

// File: rtl/pulse_stretch_sat_counter.sv
// ============================================================================
// pulse_stretch_sat_counter : 3-bit saturating up/down queue counter | rev 1.0
// ============================================================================
`default_nettype none

module pulse_stretch_sat_counter #(
  parameter int MAX = 7
) (
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic       clr,
  input  wire logic       inc,
  input  wire logic       dec,
  output logic      [2:0] value,
  output logic            overflow
);

  logic [2:0] base;
  logic [2:0] value_nxt;
  logic       overflow_nxt;

  // Clear is applied before the inc/dec so a same-cycle increment survives it.
  always_comb begin
    base         = clr ? 3'd0 : value;
    value_nxt    = base;
    overflow_nxt = 1'b0;
    if (inc && !dec) begin
      if (base >= 3'(MAX)) begin
        overflow_nxt = 1'b1;
      end else begin
        value_nxt = base + 3'd1;
      end
    end else if (dec && !inc) begin
      if (base != 3'd0) begin
        value_nxt = base - 3'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      value    <= value_nxt;
      overflow <= overflow_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pulse_stretch.sv
// ============================================================================
// pulse_stretch : strobe to min-high / min-low pulse stretcher | rev 1.0
// ============================================================================
`default_nettype none

module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int HIGH_CYCLES = DEFAULT_CYCLES,
  parameter int LOW_CYCLES  = DEFAULT_CYCLES,
  parameter int PEND_MAX    = 7,
  parameter int CW          = 19
) (
  input  wire logic        clock,
  input  wire logic        reset,
  pulse_stretch_if.slave   bus
);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            q_inc;
  logic            q_dec;
  logic            pend_avail;
  logic            high_last;
  logic            gap_last;
  logic            stretched_r;
  logic            busy_r;

  // A clear in the same cycle empties the queue before it can be consumed.
  assign pend_avail = (bus.pending != '0) && !bus.clear;
  assign high_last  = (count == CW'(HIGH_CYCLES - 1));
  assign gap_last   = (count == CW'(LOW_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    q_inc     = 1'b0;
    q_dec     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.trigger) begin
          state_nxt = HIGH;
          count_nxt = '0;
        end
      end
      HIGH: begin
        q_inc = bus.trigger;
        if (high_last) begin
          state_nxt = GAP;
          count_nxt = '0;
        end else begin
          count_nxt = count + CW'(1);
        end
      end
      GAP: begin
        if (gap_last) begin
          count_nxt = '0;
          if (pend_avail || bus.trigger) begin
            state_nxt = HIGH;
            q_dec     = pend_avail;
            q_inc     = bus.trigger && pend_avail;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          count_nxt = count + CW'(1);
          q_inc     = bus.trigger;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      stretched_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      stretched_r <= (state_nxt == HIGH);
      busy_r      <= (state_nxt != IDLE);
    end
  end

  pulse_stretch_sat_counter #(
    .MAX (PEND_MAX)
  ) u_pend (
    .clock    (clock),
    .reset    (reset),
    .clr      (bus.clear),
    .inc      (q_inc),
    .dec      (q_dec),
    .value    (bus.pending),
    .overflow (bus.overflow)
  );

  assign bus.stretched = stretched_r;
  assign bus.busy      = busy_r;

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretch.sv
// ============================================================================
// tb_pulse_stretch : directed stimulus with per-cycle scoreboard | rev 1.0
// ============================================================================
`default_nettype none

module tb_pulse_stretch;

  localparam int H  = 4;
  localparam int L  = 3;
  localparam int PM = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pulse_stretch_if bus();

  pulse_stretch #(
    .HIGH_CYCLES (H),
    .LOW_CYCLES  (L),
    .PEND_MAX    (PM),
    .CW          (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [5:0] sb[$];

  // reference: phase with a down-counting time budget and an integer queue
  int m_ph   = 0;
  int m_left = 0;
  int m_q    = 0;
  bit m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic enq_model();
    if (m_q < PM) m_q++;
    else m_ovf = 1'b1;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ph   = 0;
      m_left = 0;
      m_q    = 0;
      m_ovf  = 1'b0;
      sb.delete();
    end else begin
      m_ovf = 1'b0;
      if (bus.clear) m_q = 0;
      case (m_ph)
        0: begin
          if (bus.trigger) begin
            m_ph   = 1;
            m_left = H;
          end
        end
        1: begin
          if (bus.trigger) enq_model();
          m_left--;
          if (m_left == 0) begin
            m_ph   = 2;
            m_left = L;
          end
        end
        default: begin
          if (m_left == 1) begin
            if (m_q > 0) begin
              m_q--;
              if (bus.trigger) m_q++;
              m_ph   = 1;
              m_left = H;
            end else if (bus.trigger) begin
              m_ph   = 1;
              m_left = H;
            end else begin
              m_ph = 0;
            end
          end else begin
            m_left--;
            if (bus.trigger) enq_model();
          end
        end
      endcase
      sb.push_back({(m_ph == 1), (m_ph != 0), 3'(m_q), m_ovf});
    end
  end

  logic [5:0] sb_exp;
  always @(negedge clock) begin
    if (reset === 1'b1 && sb.size() != 0) begin
      sb_exp = sb.pop_front();
      chk("cycle", {2'b00, bus.stretched, bus.busy, bus.pending, bus.overflow}, {2'b00, sb_exp});
    end
  end

  int  hi_cnt, bz_cnt, rises, ovf_cnt, mx;
  bit  prev_s;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_stats();
    hi_cnt  = 0;
    bz_cnt  = 0;
    rises   = 0;
    ovf_cnt = 0;
    mx      = 0;
    prev_s  = bus.stretched;
  endtask

  task automatic sample();
    if (bus.stretched && !prev_s) rises++;
    if (bus.stretched) hi_cnt++;
    if (bus.busy) bz_cnt++;
    if (bus.overflow) ovf_cnt++;
    if (int'(bus.pending) > mx) mx = int'(bus.pending);
    prev_s = bus.stretched;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk(tag, {7'd0, bus.busy}, 8'd0);
  endtask

  initial begin
    bus.trigger = 1'b0;
    bus.clear   = 1'b0;

    repeat (3) step();
    chk("rst_stretched", {7'd0, bus.stretched}, 8'd0);
    chk("rst_busy",      {7'd0, bus.busy},      8'd0);
    chk("rst_pending",   {5'd0, bus.pending},   8'd0);
    chk("rst_overflow",  {7'd0, bus.overflow},  8'd0);
    reset = 1'b1;

    repeat (20) begin
      step();
      chk("idle", {2'b00, bus.stretched, bus.busy, bus.pending, bus.overflow}, 8'd0);
    end

    // single strobe
    clr_stats();
    bus.trigger = 1'b1;
    step();
    bus.trigger = 1'b0;
    chk("single_latency", {7'd0, bus.stretched}, 8'd1);
    sample();
    repeat (10) begin
      step();
      sample();
    end
    chk("single_high_cycles", 8'(hi_cnt), 8'(H));
    chk("single_busy_cycles", 8'(bz_cnt), 8'(H + L));

    // three back-to-back strobes
    clr_stats();
    bus.trigger = 1'b1;
    repeat (3) begin
      step();
      sample();
    end
    bus.trigger = 1'b0;
    repeat (25) begin
      step();
      sample();
    end
    chk("burst3_peak_pending", 8'(mx), 8'd2);
    chk("burst3_pulses",       8'(rises), 8'd3);
    chk("burst3_high_cycles",  8'(hi_cnt), 8'(3 * H));
    chk("burst3_idle_pending", {5'd0, bus.pending}, 8'd0);

    // saturation: one start strobe then 12 strobes while busy
    clr_stats();
    bus.trigger = 1'b1;
    step();
    sample();
    repeat (12) begin
      step();
      sample();
    end
    bus.trigger = 1'b0;
    chk("sat_peak_pending",  8'(mx), 8'(PM));
    chk("sat_overflow_cnt",  8'(ovf_cnt), 8'd4);
    chk("sat_no_wrap",       {5'd0, bus.pending}, 8'(PM));
    wait_idle("sat_drain_timeout");

    // strobe on the last gap cycle with an empty queue
    bus.trigger = 1'b1;
    step();
    bus.trigger = 1'b0;
    repeat (H + L - 1) step();
    chk("lastgap_pre_stretched", {7'd0, bus.stretched}, 8'd0);
    chk("lastgap_pre_busy",      {7'd0, bus.busy},      8'd1);
    bus.trigger = 1'b1;
    step();
    bus.trigger = 1'b0;
    chk("lastgap_rehigh",  {7'd0, bus.stretched}, 8'd1);
    chk("lastgap_pending", {5'd0, bus.pending},   8'd0);
    wait_idle("lastgap_drain_timeout");

    // clear + trigger with pending=5 mid-HIGH, then reset mid-HIGH
    bus.trigger = 1'b1;
    step();
    repeat (5) step();
    bus.trigger = 1'b0;
    chk("clr_fill5", {5'd0, bus.pending}, 8'd5);
    step();
    step();
    bus.trigger = 1'b1;
    step();
    chk("clr_pre_pending", {5'd0, bus.pending}, 8'd5);
    bus.clear = 1'b1;
    step();
    bus.trigger = 1'b0;
    bus.clear   = 1'b0;
    chk("clr_trig_pending", {5'd0, bus.pending},   8'd1);
    chk("clr_keeps_pulse",  {7'd0, bus.stretched}, 8'd1);
    step();
    chk("clr_pulse_tail",   {7'd0, bus.stretched}, 8'd1);
    step();
    chk("clr_pulse_end",    {7'd0, bus.stretched}, 8'd0);
    repeat (L) step();
    chk("clr_replay", {7'd0, bus.stretched}, 8'd1);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_stretched", {7'd0, bus.stretched}, 8'd0);
    chk("async_rst_busy",      {7'd0, bus.busy},      8'd0);
    chk("async_rst_pending",   {5'd0, bus.pending},   8'd0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("post_rst_idle", {7'd0, bus.busy}, 8'd0);
    bus.trigger = 1'b1;
    step();
    bus.trigger = 1'b0;
    chk("post_rst_start", {7'd0, bus.stretched}, 8'd1);
    wait_idle("post_rst_drain_timeout");

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
- Output-side counterpart to input debouncing.
- Debouncing requires an input to be stable for a set time before passing it on. This block guarantees that a generated output stays stable for a set time.
- Converts single-cycle event strobes from core logic into outputs with a guaranteed minimum high time and minimum low gap. Typical loads: LEDs, external strobes, slow peripherals.
- Strobes that arrive while a pulse is in flight are queued and replayed in order.

Parameters:
- HIGH_CYCLES, 333333: width of each output pulse in clocks. Must be ≥1.
- LOW_CYCLES, 333333: minimum low gap after each pulse in clocks. Must be ≥1.
- PEND_MAX, 7: saturation limit of the queued-strobe counter. Must be ≤7.
- CW, 19: counter width. Must hold max(HIGH_CYCLES, LOW_CYCLES)-1.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- trigger  in  1  single-cycle event strobe; each high cycle is one event.
- clear  in  1  synchronous; discards all queued events.
- stretched  out  1  registered stretched pulse output.
- busy  out  1  high whenever state is not IDLE.
- pending  out  3  number of queued events not yet emitted.
- overflow  out  1  one-cycle pulse when an event is dropped because the queue is full.

Behaviour:
- Reset (reset=0, async): state=IDLE, count=0, pending=0, stretched=0, busy=0, overflow=0.
- States:
  - IDLE: stretched=0.
  - HIGH: stretched=1.
  - GAP: stretched=0.
- IDLE:
  - trigger=1 → HIGH on the next edge, count=0.
  - Latency from trigger to stretched=1 is exactly one clock.
- HIGH:
  - count increments each cycle.
  - When count==HIGH_CYCLES-1 → GAP, count=0.
  - stretched is high for exactly HIGH_CYCLES cycles.
- GAP:
  - count increments each cycle.
  - When count==LOW_CYCLES-1, go to HIGH with count=0 if pending>0 (pending decrements) or trigger=1 this cycle. Otherwise go to IDLE.
- Queueing (trigger=1 while state is HIGH or GAP):
  - If pending<PEND_MAX: pending+1.
  - Else: event dropped, overflow=1 for that cycle.
- Simultaneous events:
  - Trigger on the last GAP cycle with pending>0: decrement and increment cancel; pending unchanged.
  - Trigger on the last GAP cycle with pending=0: consumed directly into HIGH; pending stays 0.
  - Trigger on the last HIGH cycle: queued (state is still HIGH).
- clear:
  - pending←0 on the next edge.
  - Does not abort the current HIGH or GAP; the gap always completes.
  - clear and trigger in the same cycle while busy: pending←1 (clear applies first, then the trigger is counted).
  - clear and trigger in the same cycle while IDLE: pulse starts normally.
- Minimum period between rising edges of stretched: HIGH_CYCLES+LOW_CYCLES.
- Arithmetic:
  - pending arithmetic is saturating; never wraps.
  - count never exceeds max(HIGH_CYCLES, LOW_CYCLES)-1.
- Outputs: stretched, busy and overflow are all registered; no combinational path from inputs to outputs.
- Reset mid-pulse: stretched drops to 0 asynchronously, queue lost. The first trigger after reset release behaves as from IDLE.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, HIGH=2'd1, GAP=2'd2;
  - default timing constant: 333333 = 0.01 s at 33.3333 MHz.
- One natural sub-module, sat_counter: a 3-bit saturating up/down counter with sync clear and an overflow flag. It implements the pending queue.
- FSM and timing counter stay in pulse_stretch.

Test Plan (HIGH_CYCLES=4, LOW_CYCLES=3, PEND_MAX=7):
- Reset held low, then released, with no triggers → stretched=0, busy=0, pending=0 for 20 cycles.
- Single trigger at cycle 10 → stretched=1 cycles 11–14, busy=1 cycles 11–17, busy=0 at cycle 18.
- Three triggers at cycles 10, 11, 12 → pending peaks at 2. stretched high at cycles 11–14, 18–21 and 25–28, low between. pending returns to 0 at cycle 25.
- Trigger on every cycle for 12 cycles starting while busy → pending saturates at 7, overflow pulses once per extra trigger, no wrap to 0.
- Trigger exactly on the last GAP cycle with pending=0 → next cycle HIGH, no IDLE cycle, pending stays 0.
- clear and trigger in the same cycle with pending=5 mid-HIGH → pending=1 next cycle, current pulse completes full width. Then assert reset=0 mid-HIGH → stretched=0 immediately, pending=0.
